// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter between two
//            byte sources. Requester 0 is the RX echo path and requester 1 is
//            the VGA status/button reporter. The block sequences the TX
//            core's start/busy handshake. If the core never reports busy
//            after a start, the block recovers through a bounded wait.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT      cycles to wait for tx_busy after tx_start (minimum 2)
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   req0_valid   requester 0 has a byte           req0_data  its byte
//   req0_ready   requester 0 byte taken this cycle (valid & ready)
//   req1_valid   requester 1 has a byte           req1_data  its byte
//   req1_ready   requester 1 byte taken this cycle (valid & ready)
//   tx_start     one-cycle start pulse to the TX core
//   tx_data      byte to transmit; stable from tx_start until back in IDLE
//   tx_busy      TX core is shifting a frame
//   grant        one-hot owner of the in-flight byte, 00 when idle
//   timeout_err  one-cycle pulse when the wait for tx_busy expires
// ============================================================================
module uart_tx_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] counter;
    logic             last;          // requester served most recently
    logic             pick;          // requester that would win this cycle
    logic             accept;
    logic             busy_timeout;

    // ------------------------------------------------------------------
    // Round-robin pick: a lone requester always wins; on a tie the one
    // not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output / handshake decode. Ready is a combinational function of
    // valid, so requesters must not gate valid with ready.
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready   = (state == S_IDLE) && !tx_busy && req0_valid && !pick;
        req1_ready   = (state == S_IDLE) && !tx_busy && req1_valid &&  pick;
        accept       = req0_ready || req1_ready;
        // Busy wins over an expiry landing in the same cycle, so only
        // an idle core at the final count is a timeout.
        busy_timeout = (state == S_WAIT_BUSY) && !tx_busy && (counter >= CNT_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    next_state = S_WAIT_DONE;
                end else if (busy_timeout) begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, arbitration history and the busy-wait counter.
    // A reset here aborts any in-flight byte; the owner must re-present it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
            counter     <= '0;
            last        <= 1'b1;
        end else begin
            // High exactly while the FSM sits in START.
            tx_start    <= (next_state == S_START);
            timeout_err <= busy_timeout;

            if (accept) begin
                tx_data <= pick ? req1_data : req0_data;
                grant   <= pick ? 2'b10 : 2'b01;
                last    <= pick;
            end else if (next_state == S_IDLE) begin
                grant   <= 2'b00;
            end

            // Counts cycles spent in WAIT_BUSY; zero on entry, saturating.
            if (state == S_WAIT_BUSY) begin
                if (counter != CNT_MAX) begin
                    counter <= counter + 1'b1;
                end
            end else begin
                counter <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Directed stimulus
//            pushes hand-computed expected bytes/grants into a scoreboard.
//            A monitor pops and compares on every tx_start. A small TX core
//            model drives tx_busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;

    uart_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] grant;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int   start_q[$];
    int   te_q[$];
    int   acc_order[$];
    int   acc_cyc_q[$];
    int   ready_both = 0;
    int   te_grant_nz = 0;
    bit   model_en = 1'b0;
    bit   force_busy = 1'b0;
    int   bdelay = 2;
    int   blen = 4;
    int   s_cyc = -1000;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TX core model: busy high in cycles S+bdelay .. S+bdelay+blen-1,
    // where S is the cycle tx_start was seen.
    always @(negedge clk) begin : busy_model
        if (tx_start) s_cyc = cyc;
        tx_busy = force_busy ||
                  (model_en && (cyc >= s_cyc + bdelay) && (cyc < s_cyc + bdelay + blen));
    end

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (tx_start) begin
            start_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx_start: got data %h grant %b, required no start", tx_data, grant);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.data || grant !== e.grant) begin
                    errors++;
                    $display("FAIL tx_byte: got data %h grant %b, required data %h grant %b",
                             tx_data, grant, e.data, e.grant);
                end
            end
        end
        if (timeout_err) begin
            te_q.push_back(cyc);
            if (grant !== 2'b00) te_grant_nz++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    // One cycle: present requester queues, sample handshake after settling.
    task automatic step();
        @(negedge clk);
        req0_valid = (q0.size() > 0);
        req0_data  = req0_valid ? q0[0] : 8'h00;
        req1_valid = (q1.size() > 0);
        req1_data  = req1_valid ? q1[0] : 8'h00;
        #1;
        if (req0_ready && req1_ready) ready_both++;
        if (req0_valid && req0_ready) begin
            void'(q0.pop_front());
            acc_order.push_back(0);
            acc_cyc_q.push_back(cyc);
        end
        if (req1_valid && req1_ready) begin
            void'(q1.pop_front());
            acc_order.push_back(1);
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic run_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                grant == 2'b00 && !tx_busy && !tx_start) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_wait: got still busy after %0d cycles, required idle", maxc);
    endtask

    // After the first tx_start, find the first cycle with grant back at 00.
    task automatic wait_grant_clear(input logic [1:0] g, output int first_zero, output int bad);
        first_zero = -1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (start_q.size() > 0) begin
                if (grant == 2'b00) begin
                    first_zero = cyc;
                    return;
                end else if (grant != g) begin
                    bad++;
                end
            end
        end
    endtask

    initial begin : stimulus
        int fz;
        int bad;
        int pat;
        int rdy;
        bit pushed;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;

        // ---------------- tie after reset ----------------
        model_en = 1'b1; bdelay = 2; blen = 4;
        acc_order.delete(); ready_both = 0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'hAA);
            q1.push_back(8'h55);
            exp_q.push_back('{data: 8'hAA, grant: 2'b01});
            exp_q.push_back('{data: 8'h55, grant: 2'b10});
        end
        run_idle(200);
        pat = 0;
        foreach (acc_order[i]) pat = pat * 2 + acc_order[i];
        chk("tie_count", acc_order.size(), 6);
        chk("tie_alternation", pat, 21);
        chk("ready_exclusive", ready_both, 0);

        // ---------------- single byte ----------------
        start_q.delete(); acc_order.delete(); acc_cyc_q.delete();
        bdelay = 2; blen = 10;
        q0.push_back(8'h41);
        exp_q.push_back('{data: 8'h41, grant: 2'b01});
        wait_grant_clear(2'b01, fz, bad);
        chk("single_accept_count", acc_order.size(), 1);
        chk("single_start_latency", (start_q.size() > 0 && acc_cyc_q.size() > 0) ?
            start_q[0] - acc_cyc_q[0] : -1, 1);
        chk("single_grant_release", (start_q.size() > 0 && fz >= 0) ? fz - start_q[0] : -1, 13);
        chk("single_grant_held", bad, 0);
        run_idle(20);

        // ---------------- timeout ----------------
        start_q.delete(); te_q.delete(); acc_order.delete(); acc_cyc_q.delete();
        model_en = 1'b0; te_grant_nz = 0; pushed = 1'b0;
        q0.push_back(8'h11);
        exp_q.push_back('{data: 8'h11, grant: 2'b01});
        exp_q.push_back('{data: 8'h22, grant: 2'b10});
        for (int i = 0; i < 60; i++) begin
            step();
            if (acc_order.size() == 1 && !pushed) begin
                q1.push_back(8'h22);
                pushed = 1'b1;
            end
            if (te_q.size() >= 2) break;
        end
        chk("timeout_pulses", te_q.size(), 2);
        chk("timeout_delay", (te_q.size() > 0 && start_q.size() > 0) ? te_q[0] - start_q[0] : -1, 9);
        chk("timeout_next_accept", (te_q.size() > 0 && acc_cyc_q.size() > 1) ?
            acc_cyc_q[1] - te_q[0] : -1, 0);
        chk("timeout_spacing", (te_q.size() > 1) ? te_q[1] - te_q[0] : -1, 10);
        chk("timeout_grant_clear", te_grant_nz, 0);
        run_idle(20);

        // ---------------- busy / timeout coincidence ----------------
        start_q.delete(); te_q.delete();
        model_en = 1'b1; bdelay = 8; blen = 3;
        q0.push_back(8'h33);
        exp_q.push_back('{data: 8'h33, grant: 2'b01});
        wait_grant_clear(2'b01, fz, bad);
        chk("coincide_no_timeout", te_q.size(), 0);
        chk("coincide_wait_done", (start_q.size() > 0 && fz >= 0) ? fz - start_q[0] : -1, 12);
        run_idle(20);

        // ---------------- reset mid-frame ----------------
        start_q.delete();
        model_en = 1'b1; bdelay = 2; blen = 10;
        q0.push_back(8'h44);
        exp_q.push_back('{data: 8'h44, grant: 2'b01});
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_q.size() > 0) break;
        end
        repeat (5) step();
        force_busy = 1'b1; model_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        q0.push_back(8'h5A);
        q1.push_back(8'hA5);
        acc_order.delete(); rdy = 0;
        repeat (5) begin
            step();
            if (req0_ready || req1_ready) rdy++;
        end
        chk("midrst_no_ready_busy", rdy, 0);
        force_busy = 1'b0; model_en = 1'b1; bdelay = 2; blen = 3;
        exp_q.push_back('{data: 8'h5A, grant: 2'b01});
        exp_q.push_back('{data: 8'hA5, grant: 2'b10});
        run_idle(80);
        chk("midrst_order", (acc_order.size() == 2) ? acc_order[0] * 2 + acc_order[1] : -1, 1);

        // ---------------- busy in IDLE ----------------
        start_q.delete(); acc_order.delete();
        force_busy = 1'b1; model_en = 1'b0; rdy = 0;
        q1.push_back(8'h66);
        repeat (6) begin
            step();
            if (req1_ready) rdy++;
        end
        chk("idlebusy_no_ready", rdy, 0);
        chk("idlebusy_no_start", start_q.size(), 0);
        force_busy = 1'b0; model_en = 1'b1; bdelay = 2; blen = 3;
        exp_q.push_back('{data: 8'h66, grant: 2'b10});
        run_idle(40);
        chk("idlebusy_accept", (acc_order.size() == 1) ? acc_order[0] : -1, 1);

        chk("ready_exclusive_all", ready_both, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte sources: requester 0 is the RX echo path and requester 1 is the VGA status/button reporter. It sits between those sources and the uart TX core inside system. Requesters are served round-robin. The block sequences the TX core's start/busy handshake and recovers from a TX core that never reports busy.

Parameters:
TIMEOUT, 1024, maximum cycles to wait in WAIT_BUSY for tx_busy to rise after tx_start; minimum legal value 2.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req0_valid  input  1  requester 0 has a byte
req0_data  input  8  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has a byte
req1_data  input  8  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready
tx_start  output  1  one-cycle start pulse to the TX core
tx_data  output  8  byte to transmit; held stable from tx_start until return to IDLE
tx_busy  input  1  TX core is shifting a frame
grant  output  2  one-hot owner of the in-flight byte; 00 when idle
timeout_err  output  1  one-cycle pulse when the WAIT_BUSY timeout expires

Behaviour:
- Reset is synchronous and active-low; all state updates on rising clk.
- While rst_n=0 on a clock edge: state=IDLE, tx_start=0, tx_data=0, grant=00, timeout_err=0, counter=0, last=1 (req0 wins the first tie).
- Reset mid-operation aborts the byte with no further tx_start. Requesters re-present the byte.
- States:
  - IDLE -> START on accept.
  - START -> WAIT_BUSY unconditionally.
  - WAIT_BUSY -> WAIT_DONE when tx_busy=1.
  - WAIT_BUSY -> IDLE when counter reaches TIMEOUT-1 with tx_busy=0.
  - WAIT_DONE -> IDLE when tx_busy=0.
- Pick (combinational):
  - only req0_valid -> 0; only req1_valid -> 1.
  - Both valid -> the requester other than last.
- Ready:
  - reqN_ready = (state==IDLE) && !tx_busy && reqN_valid && pick==N.
  - At most one ready is high in any cycle. Ready is never high outside IDLE.
  - This is a combinational valid->ready path; requesters must not make valid depend on ready.
- Accept cycle (IDLE, valid&ready):
  - tx_data <= chosen data; grant <= one-hot(N); last <= N; state <= START.
- START: tx_start=1 for exactly this one cycle, registered. Latency is accept at edge k, tx_start high in cycle k+1.
- WAIT_BUSY:
  - Counter increments each cycle, starting at 0 on entry.
  - If tx_busy rises in the same cycle the counter hits TIMEOUT-1, busy wins: go to WAIT_DONE, no error.
- Timeout exit: timeout_err=1 for one cycle (the cycle IDLE is entered); grant -> 00. The byte is dropped, not retried.
- WAIT_DONE: hold grant and tx_data. On tx_busy=0, go to IDLE and grant -> 00. A new accept is possible in the first IDLE cycle.
- Throughput: at most one byte per frame. Back-to-back bytes from persistent requesters alternate 0,1,0,1.
- Counter is width $clog2(TIMEOUT+1) and saturates; it never wraps.
- tx_busy=1 while in IDLE (core still busy or externally driven): no ready is asserted until it falls.

Test Plan:
- Single byte: req0_valid=1, data=8'h41, TX model raises busy 2 cycles after start for 10 cycles -> req0_ready high 1 cycle, tx_start 1 cycle later with tx_data=8'h41, grant=01 until busy falls, then 00.
- Tie after reset: both valid, data 8'hAA/8'h55 held -> req0 served first (tx_data=AA), then req1 (tx_data=55), then req0 again. Check strict alternation over 6 bytes and that ready is never high for both.
- Timeout: TIMEOUT=8, TX model never raises busy -> timeout_err pulses exactly 8 cycles after WAIT_BUSY entry, grant=00, next request accepted on the following cycle.
- Busy/timeout coincidence: TIMEOUT=8, busy rises on counter=7 -> WAIT_DONE entered, no timeout_err.
- Reset mid-frame: rst_n=0 for 1 cycle during WAIT_DONE with busy still high -> next cycle all outputs 0, state IDLE. No ready while busy stays high; accept resumes after busy falls, and req0 wins a tie.
- Busy in IDLE: tx_busy=1 externally, req1_valid=1 -> req1_ready stays 0 and tx_start stays 0 until busy drops, then accept.
